multicycle_control_fsm: RTL

Multi-cycle control sequencer for the 24-bit CPU datapath. It replaces the single-cycle combinational control unit and drives the same control signals, plus PC and instruction-register write enables. Execution is split into FETCH/DECODE/EXEC/MEM/WB steps. The block waits on a data-memory ready handshake, so the datapath can later share a single slow memory.

---
 rtl/cpu24_ctrl_pkg.sv | 36 +++
 rtl/perf_counters.sv | 25 ++
 rtl/multicycle_control_fsm.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cpu24_ctrl_pkg.sv
// Shared constants for the 24-bit CPU multi-cycle control sequencer:
// opcodes, ALUOp encodings, FSM state encoding and an opcode legality helper.
package cpu24_ctrl_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b1000;
    localparam logic [3:0] OP_SW    = 4'b1001;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_BNE   = 4'b0101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW,
            OP_BEQ, OP_BNE, OP_HALT: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/perf_counters.sv
// Cycle and retired-instruction counters for the control sequencer.
// Only instantiated when PERF_COUNTER_EN is defined.
module perf_counters #(
    parameter int WIDTH = 24
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             active,
    input  logic             retire,
    output logic [WIDTH-1:0] cycle_count,
    output logic [WIDTH-1:0] instr_count
);

    // Both counters wrap naturally modulo 2^WIDTH.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (active) cycle_count <= cycle_count + 1'b1;
            if (retire) instr_count <= instr_count + 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the 24-bit CPU.
// Define PERF_COUNTER_EN to build the cycle/instruction performance counters.
module multicycle_control_fsm #(
    parameter int RESET_PC_HOLD = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [3:0]  opcode,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        Branch,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        ALUSrc,
    output logic [1:0]  ALUOp,
    output logic        Halted,
    output logic        Illegal,
    output logic [23:0] cycle_count,
    output logic [23:0] instr_count
);
    import cpu24_ctrl_pkg::*;

    localparam int HOLD_W = (RESET_PC_HOLD > 1) ? $clog2(RESET_PC_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_PC_HOLD);

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [3:0]        op_q;
    logic              illegal_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= ST_IDLE;
            hold_cnt  <= HOLD_INIT;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && hold_cnt != '0)
                hold_cnt <= hold_cnt - HOLD_W'(1);
            if (state == ST_DECODE) begin
                op_q <= opcode;
                if (!is_legal_op(opcode))
                    illegal_q <= 1'b1;
            end
        end
    end

    assign Illegal = illegal_q;

    // Moore decode on (state, op_q); PCWriteCond alone follows Zero live in EXEC.
    always_comb begin
        state_nxt   = state;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        Branch      = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        MemToReg    = 1'b0;
        ALUSrc      = 1'b0;
        ALUOp       = ALUOP_ADD;
        Halted      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (hold_cnt == '0 && Start)
                    state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (opcode == OP_HALT || !is_legal_op(opcode))
                    state_nxt = ST_HALT;
                else
                    state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                case (op_q)
                    OP_RTYPE: begin
                        ALUOp     = ALUOP_FUNCT;
                        state_nxt = ST_WB;
                    end
                    OP_ADDI: begin
                        ALUOp     = ALUOP_ITYPE;
                        ALUSrc    = 1'b1;
                        state_nxt = ST_WB;
                    end
                    OP_LW, OP_SW: begin
                        ALUOp     = ALUOP_ADD;
                        ALUSrc    = 1'b1;
                        state_nxt = ST_MEM;
                    end
                    OP_BEQ: begin
                        ALUOp       = ALUOP_SUB;
                        Branch      = 1'b1;
                        PCWriteCond = Zero;
                        state_nxt   = ST_FETCH;
                    end
                    OP_BNE: begin
                        ALUOp       = ALUOP_SUB;
                        Branch      = 1'b1;
                        PCWriteCond = ~Zero;
                        state_nxt   = ST_FETCH;
                    end
                    default: state_nxt = ST_HALT;
                endcase
            end
            ST_MEM: begin
                // Address path held steady for the whole wait.
                ALUOp    = ALUOP_ADD;
                ALUSrc   = 1'b1;
                MemRead  = (op_q == OP_LW);
                MemWrite = (op_q == OP_SW);
                if (MemReady)
                    state_nxt = (op_q == OP_LW) ? ST_WB : ST_FETCH;
            end
            ST_WB: begin
                RegWrite  = 1'b1;
                RegDst    = (op_q == OP_RTYPE);
                MemToReg  = (op_q == OP_LW);
                state_nxt = ST_FETCH;
            end
            ST_HALT: begin
                Halted = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef PERF_COUNTER_EN
    logic active, retire;

    assign active = (state != ST_IDLE) && (state != ST_HALT);
    assign retire = (state == ST_WB)
                  || (state == ST_EXEC && (op_q == OP_BEQ || op_q == OP_BNE))
                  || (state == ST_MEM && op_q == OP_SW && MemReady);

    perf_counters #(.WIDTH(24)) u_perf (
        .Clock       (Clock),
        .Reset       (Reset),
        .active      (active),
        .retire      (retire),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule
